sap_microsequencer: RTL and testbench
=====================================

// Module: sap_microsequencer
// PURPOSE
//  Parametrised SAP-1 control sequencer with variable-length instructions.
//  Fetch is T0-T2; execute runs T3-T5 and wraps to T0 early when the opcode is done.
//  Stalls on multi-cycle MUL/DIV units until unit_done, with a timeout. Latches HALT.
//  Sits between IR opcode field and the datapath control bus.
// PARAMETERS
//  OPC_W      4   opcode width; HLT opcode = all ones, others compared zero-extended
//  CW_W       14  control word width, >=14; bits [CW_W-1:14] always 0
//  STALL_MAX  15  max cycles T5 waits for unit_done before abort (1..255)
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  opcode     in   OPC_W  IR opcode field, valid from T3 onward
//  unit_done  in   1      MUL/DIV result ready (sampled in T5 only)
//  out        out  CW_W   control word for current T-state
//  tstate     out  3      current T-state 0..5 (7 = HALT)
//  instr_done out  1      high in final cycle of each non-HLT instruction
//  halted     out  1      sticky, set on HLT
//  stall_err  out  1      sticky, set on MUL/DIV timeout
// BEHAVIOUR
//  Control bits: 13 DIV_EN, 12 MUL_EN, 11 HLT, 10 PC_INC, 9 PC_EN, 8 MEM_LOAD, 7 MEM_EN,
//   6 IR_LOAD, 5 IR_EN, 4 A_LOAD, 3 A_EN, 2 B_LOAD, 1 SUB, 0 ADDER_EN.
//  Opcodes: LDA 0, ADD 1, SUB 2, MUL 3, DIV 4, HLT all-ones; any other = NOP.
//  Reset: tstate=0, halted=0, stall_err=0, stall counter=0, op_q=0; while rst=1 out=0, instr_done=0.
//  out/instr_done are decoded from registered state (tstate, op_q, stall count) plus live opcode (T3)
//   and unit_done (T5); they change only when state changes or those inputs change.
//  T0: PC_EN|MEM_LOAD.  T1: PC_INC.  T2: MEM_EN|IR_LOAD.
//  T3 (live opcode; captured into op_q at end of T3):
//   LDA/ADD/SUB/MUL/DIV: IR_EN|MEM_LOAD -> T4.  HLT: HLT bit -> HALT.  NOP: out=0, instr_done -> T0.
//  T4 (op_q): LDA: MEM_EN|A_LOAD, instr_done -> T0.  ADD/SUB/MUL/DIV: MEM_EN|B_LOAD -> T5.
//  T5 (op_q): ADD: ADDER_EN|A_LOAD.  SUB: ADDER_EN|SUB|A_LOAD.  Both: instr_done -> T0.
//   MUL/DIV: MUL_EN or DIV_EN held each cycle; stall counter counts T5 cycles.
//    unit_done=1: also A_LOAD, instr_done, -> T0, counter cleared.
//    unit_done=0 and counter==STALL_MAX-1: no A_LOAD, instr_done, stall_err<=1, -> T0.
//    otherwise stay in T5, counter+1.
//  Cycle counts: NOP 4, LDA 5, ADD/SUB 6, MUL/DIV 6+k with k = stall cycles (k<=STALL_MAX-1).
//  HALT: out = HLT bit only, tstate=7, halted=1; opcode/unit_done ignored; exits only by rst.
//  unit_done outside T5 ignored. opcode changes after T3 ignored (op_q used).
//  rst mid-instruction/mid-stall: next cycle T0, all sticky flags cleared.
//  Undefined opcode with OPC_W>4 upper bits set (not all-ones) = NOP.
// CONFIGURATION
//  SAP_SEQ_STEP_EN defined: extra input port step (1 bit). State (tstate, op_q, counter) advances
//   only on cycles with step=1; otherwise held, out held stable, instr_done held.
//   Stall counter counts only stepped cycles. HALT and rst unaffected by step.
//  Not defined: no step port; sequencer advances every cycle.
// TESTING
//  rst 2 cycles, opcode=0 (LDA) -> out: 0x0300,0x0400,0x00C0,0x0120,0x0090; instr_done at T4; back to T0.
//  ADD(1) then SUB(2) -> T5 out 0x0011 then 0x0013; each instr 6 cycles; opcode toggled in T4 ignored.
//  MUL(3), unit_done raised 3rd T5 cycle -> out 0x1000,0x1000,0x1010; instr_done once; 8 cycles total.
//  DIV(4), unit_done never, STALL_MAX=15 -> 15 T5 cycles of 0x2000, stall_err=1, T0 next, no A_LOAD.
//  HLT(0xF) at T3 -> out 0x0800, tstate=7, halted=1 forever; rst -> T0, halted=0.
//  opcode=7 (NOP) -> T3 out=0, instr_done, 4-cycle loop; with SAP_SEQ_STEP_EN step=0 freezes tstate.

Source files
------------

// File: rtl/sap_microsequencer.sv
// SAP-1 control sequencer: fetch T0-T2, variable-length execute T3-T5, MUL/DIV stall with timeout, sticky HALT.
// Optional single-step gating of state advance when SAP_SEQ_STEP_EN is defined.
module sap_microsequencer #(
   parameter int OPC_W     = 4,
   parameter int CW_W      = 14,
   parameter int STALL_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SAP_SEQ_STEP_EN
   input  logic             step,
`endif
   input  logic [OPC_W-1:0] opcode,
   input  logic             unit_done,
   output logic [CW_W-1:0]  out,
   output logic [2:0]       tstate,
   output logic             instr_done,
   output logic             halted,
   output logic             stall_err
);

   localparam logic [13:0] DIV_EN   = 14'h2000;
   localparam logic [13:0] MUL_EN   = 14'h1000;
   localparam logic [13:0] HLT      = 14'h0800;
   localparam logic [13:0] PC_INC   = 14'h0400;
   localparam logic [13:0] PC_EN    = 14'h0200;
   localparam logic [13:0] MEM_LOAD = 14'h0100;
   localparam logic [13:0] MEM_EN   = 14'h0080;
   localparam logic [13:0] IR_LOAD  = 14'h0040;
   localparam logic [13:0] IR_EN    = 14'h0020;
   localparam logic [13:0] A_LOAD   = 14'h0010;
   localparam logic [13:0] B_LOAD   = 14'h0004;
   localparam logic [13:0] SUB      = 14'h0002;
   localparam logic [13:0] ADDER_EN = 14'h0001;

   typedef enum logic [2:0] {
      T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5, HALT = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      OP_LDA, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_HLT, OP_NOP
   } op_t;

   state_t           state, nxt;
   logic [OPC_W-1:0] op_q;
   logic [7:0]       stall_cnt, cnt_nxt;
   logic [13:0]      cw;
   logic             done, err_set, adv;
   op_t              op_live, op_reg;

   function automatic op_t classify(input logic [OPC_W-1:0] op);
      if (op == '1)                 return OP_HLT;
      else if (op == OPC_W'(0))     return OP_LDA;
      else if (op == OPC_W'(1))     return OP_ADD;
      else if (op == OPC_W'(2))     return OP_SUB;
      else if (op == OPC_W'(3))     return OP_MUL;
      else if (op == OPC_W'(4))     return OP_DIV;
      else                          return OP_NOP;
   endfunction

`ifdef SAP_SEQ_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   assign op_live = classify(opcode);
   assign op_reg  = classify(op_q);

   // Outputs are decoded from registered state plus live opcode/unit_done, not registered.
   always_comb begin
      cw      = '0;
      done    = 1'b0;
      err_set = 1'b0;
      nxt     = state;
      cnt_nxt = stall_cnt;
      case (state)
         T0: begin cw = PC_EN | MEM_LOAD; nxt = T1; end
         T1: begin cw = PC_INC;           nxt = T2; end
         T2: begin cw = MEM_EN | IR_LOAD; nxt = T3; end
         T3: begin
            if (op_live == OP_HLT) begin
               cw  = HLT;
               nxt = HALT;
            end else if (op_live == OP_NOP) begin
               done = 1'b1;
               nxt  = T0;
            end else begin
               cw  = IR_EN | MEM_LOAD;
               nxt = T4;
            end
         end
         T4: begin
            if (op_reg == OP_LDA) begin
               cw   = MEM_EN | A_LOAD;
               done = 1'b1;
               nxt  = T0;
            end else if (op_reg == OP_ADD || op_reg == OP_SUB ||
                         op_reg == OP_MUL || op_reg == OP_DIV) begin
               cw  = MEM_EN | B_LOAD;
               nxt = T5;
            end else begin
               nxt = T0;
            end
         end
         T5: begin
            if (op_reg == OP_ADD || op_reg == OP_SUB) begin
               cw   = ADDER_EN | A_LOAD | ((op_reg == OP_SUB) ? SUB : 14'h0000);
               done = 1'b1;
               nxt  = T0;
            end else if (op_reg == OP_MUL || op_reg == OP_DIV) begin
               cw = (op_reg == OP_MUL) ? MUL_EN : DIV_EN;
               if (unit_done) begin
                  cw      = cw | A_LOAD;
                  done    = 1'b1;
                  nxt     = T0;
                  cnt_nxt = '0;
               end else if (stall_cnt == 8'(STALL_MAX - 1)) begin
                  done    = 1'b1;
                  err_set = 1'b1;
                  nxt     = T0;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = stall_cnt + 8'd1;
               end
            end else begin
               nxt     = T0;
               cnt_nxt = '0;
            end
         end
         HALT:    begin cw = HLT; nxt = HALT; end
         default: nxt = T0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= T0;
         op_q      <= '0;
         stall_cnt <= '0;
         halted    <= 1'b0;
         stall_err <= 1'b0;
      end else if (adv) begin
         state     <= nxt;
         stall_cnt <= cnt_nxt;
         if (state == T3) op_q <= opcode;
         if (nxt == HALT) halted <= 1'b1;
         if (err_set) stall_err <= 1'b1;
      end
   end

   assign out        = rst ? '0 : CW_W'(cw);
   assign instr_done = rst ? 1'b0 : done;
   assign tstate     = state;

endmodule

// File: tb/tb_sap_microsequencer.sv
// Self-checking bench for sap_microsequencer: directed table, HALT/reset sequences, randomized program vs trace model.
module tb_sap_microsequencer;
   localparam int STALL_MAX = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        step = 1'b1;
   logic [3:0]  opcode = '0;
   logic        unit_done = 1'b0;
   logic [13:0] out;
   logic [2:0]  tstate;
   logic        instr_done, halted, stall_err;

   sap_microsequencer #(.OPC_W(4), .CW_W(14), .STALL_MAX(STALL_MAX)) dut (
      .clk(clk), .rst(rst),
`ifdef SAP_SEQ_STEP_EN
      .step(step),
`endif
      .opcode(opcode), .unit_done(unit_done), .out(out), .tstate(tstate),
      .instr_done(instr_done), .halted(halted), .stall_err(stall_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic model_err = 1'b0;

   typedef struct {
      logic [2:0]  ts;
      logic [13:0] cw;
      logic        done;
      logic        ud;
      logic        err;
   } cyc_t;

   typedef struct {
      logic [3:0] opc;
      int         done_at;
      int         exp_len;
      logic       exp_err;
   } row_t;

   cyc_t trace[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic cyc_t mk(input int ts, input int cw, input bit done, input bit ud, input bit err);
      cyc_t c;
      c.ts = 3'(ts); c.cw = 14'(cw); c.done = done; c.ud = ud; c.err = err;
      return c;
   endfunction

   // Expected per-cycle behaviour of one whole instruction, from the instruction-level rules.
   task automatic build(input logic [3:0] op, input int done_at);
      int en;
      trace.delete();
      trace.push_back(mk(0, 'h300, 0, 0, 0));
      trace.push_back(mk(1, 'h400, 0, 0, 0));
      trace.push_back(mk(2, 'h0C0, 0, 0, 0));
      if (op == 4'hF) begin
         trace.push_back(mk(3, 'h800, 0, 0, 0));
      end else if (op > 4) begin
         trace.push_back(mk(3, 0, 1, 0, 0));
      end else if (op == 0) begin
         trace.push_back(mk(3, 'h120, 0, 0, 0));
         trace.push_back(mk(4, 'h090, 1, 0, 0));
      end else begin
         trace.push_back(mk(3, 'h120, 0, 0, 0));
         trace.push_back(mk(4, 'h084, 0, 0, 0));
         if (op == 1)      trace.push_back(mk(5, 'h011, 1, 0, 0));
         else if (op == 2) trace.push_back(mk(5, 'h013, 1, 0, 0));
         else begin
            en = (op == 3) ? 'h1000 : 'h2000;
            for (int i = 0; i < STALL_MAX; i++) begin
               if (i == done_at) begin
                  trace.push_back(mk(5, en | 'h10, 1, 1, 0));
                  break;
               end else if (i == STALL_MAX - 1) begin
                  trace.push_back(mk(5, en, 1, 0, 1));
               end else begin
                  trace.push_back(mk(5, en, 0, 0, 0));
               end
            end
         end
      end
   endtask

   // Called at posedge+1; returns cycles until DUT instr_done (0 if never seen).
   task automatic run_instr(input logic [3:0] op, input int done_at, output int len);
      cyc_t e;
      build(op, done_at);
      len = 0;
      for (int i = 0; i < trace.size(); i++) begin
         e = trace[i];
         opcode    = (e.ts == 3) ? op : 4'($urandom);
         unit_done = (e.ts == 5) ? e.ud : 1'($urandom);
         #1;
         chk("cycle_state", {29'd0, tstate}, {29'd0, e.ts});
         chk("cycle_out", {18'd0, out}, {18'd0, e.cw});
         chk("cycle_done", {31'd0, instr_done}, {31'd0, e.done});
         chk("stall_err_flag", {31'd0, stall_err}, {31'd0, model_err});
         chk("halted_flag", {31'd0, halted}, 32'd0);
         if (instr_done === 1'b1 && len == 0) len = i + 1;
         @(posedge clk); #1;
         if (e.err) model_err = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin
         opcode = 4'($urandom);
         unit_done = 1'($urandom);
         #1;
         chk("rst_out", {18'd0, out}, 32'd0);
         chk("rst_done", {31'd0, instr_done}, 32'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      model_err = 1'b0;
      #1;
      chk("reset_tstate", {29'd0, tstate}, 32'd0);
      chk("reset_halted", {31'd0, halted}, 32'd0);
      chk("reset_stall_err", {31'd0, stall_err}, 32'd0);
      #1;
      opcode = '0;
      unit_done = 1'b0;
   endtask

   row_t rows[9];
   int   len;
   int   guard;
   logic [3:0] rop;
   int   rdone;

   initial begin
      rows[0] = '{4'd0, -1,  5, 1'b0};
      rows[1] = '{4'd1, -1,  6, 1'b0};
      rows[2] = '{4'd2, -1,  6, 1'b0};
      rows[3] = '{4'd3,  2,  8, 1'b0};
      rows[4] = '{4'd4, -1, 20, 1'b1};
      rows[5] = '{4'd7, -1,  4, 1'b0};
      rows[6] = '{4'd3,  0,  6, 1'b0};
      rows[7] = '{4'd4, 14, 20, 1'b0};
      rows[8] = '{4'd9, -1,  4, 1'b0};

      @(posedge clk); #1;
      do_reset();
      // Directed table: length of each instruction and resulting error flag.
      foreach (rows[r]) begin
         do_reset();
         run_instr(rows[r].opc, rows[r].done_at, len);
         chk($sformatf("len_op%0d", rows[r].opc), len, rows[r].exp_len);
         chk($sformatf("err_op%0d", rows[r].opc), {31'd0, stall_err}, {31'd0, rows[r].exp_err});
         chk("back_to_t0", {29'd0, tstate}, 32'd0);
      end

      // HALT is sticky regardless of inputs; only rst leaves it.
      do_reset();
      run_instr(4'd1, -1, len);
      run_instr(4'hF, -1, len);
      repeat (5) begin
         opcode = 4'($urandom);
         unit_done = 1'($urandom);
         #1;
         chk("halt_tstate", {29'd0, tstate}, 32'd7);
         chk("halt_out", {18'd0, out}, 32'h800);
         chk("halt_done", {31'd0, instr_done}, 32'd0);
         chk("halt_flag", {31'd0, halted}, 32'd1);
         @(posedge clk); #1;
      end
      do_reset();
      #1;
      chk("post_halt_out", {18'd0, out}, 32'h300);

      // Reset in the middle of a MUL stall clears the sticky error from a prior timeout.
      do_reset();
      run_instr(4'd4, -1, len);
      chk("pre_err", {31'd0, stall_err}, 32'd1);
      opcode = 4'd3;
      unit_done = 1'b0;
      guard = 0;
      while (tstate != 3'd5 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("reach_t5", {29'd0, tstate}, 32'd5);
      repeat (2) begin @(posedge clk); #1; end
      chk("still_stall", {18'd0, out}, 32'h1000);
      do_reset();

      // Randomized program against the trace model.
      for (int n = 0; n < 60; n++) begin
         rop = 4'($urandom_range(0, 14));
         rdone = $urandom_range(0, STALL_MAX + 3);
         if (rdone >= STALL_MAX) rdone = -1;
         run_instr(rop, rdone, len);
         chk("rand_len", {31'd0, len == trace.size()}, 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule
